// File: rtl/window_skew_feeder_if.sv
// window_skew_feeder_if: pixel-in / skewed-rows-out bundle for window_skew_feeder
// master: drives in_valid, in_sof, serial_pixel_in; observes rows_skewed, out_valid, out_col
// slave:  the feeder itself, the reverse directions
interface window_skew_feeder_if #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 4,
  parameter int K      = 3
);
  logic                       in_valid;
  logic                       in_sof;
  logic [DATA_W-1:0]          serial_pixel_in;
  logic [K*DATA_W-1:0]        rows_skewed;
  logic                       out_valid;
  logic [$clog2(IMG_W)-1:0]   out_col;
  modport master (output in_valid, in_sof, serial_pixel_in, input rows_skewed, out_valid, out_col);
  modport slave  (input in_valid, in_sof, serial_pixel_in, output rows_skewed, out_valid, out_col);
endinterface

// File: rtl/window_skew_feeder.sv
// window_skew_feeder: line-buffer and diagonal-skew front end presenting K aligned rows
// clk, rst (async, active-high); bus: window_skew_feeder_if slave
//   in_valid/in_sof/serial_pixel_in in; rows_skewed (lane j at [j*DATA_W +: DATA_W]), out_valid, out_col out
module window_skew_feeder #(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 4,
  parameter int K      = 3
) (
  input logic                 clk,
  input logic                 rst,
  window_skew_feeder_if.slave bus
);
  localparam int LB = (K-1)*IMG_W;
  localparam int F  = LB + 1;
  localparam int CW = $clog2(F+1);
  localparam int OW = $clog2(IMG_W);
  localparam logic [CW-1:0] FC = CW'(F);
  logic              w_adv;
  logic              w_clr;
  logic [CW-1:0]     w_cnt_nxt;
  logic [DATA_W-1:0] r_line [LB];
  logic [CW-1:0]     r_cnt;
  logic [OW-1:0]     r_col;
  logic              r_valid;
  assign w_adv = bus.in_valid;
  assign w_clr = bus.in_valid & bus.in_sof;
  always_comb w_cnt_nxt = w_clr ? CW'(1) : (r_cnt == FC ? FC : r_cnt + 1'b1);
  // r_line[i] holds the sample accepted i advances ago; SOF keeps only the new pixel
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < LB; i++) r_line[i] <= '0;
    else if (w_adv) begin
      r_line[0] <= bus.serial_pixel_in;
      for (int i = 1; i < LB; i++) r_line[i] <= w_clr ? '0 : r_line[i-1];
    end
  genvar j;
  generate
    for (j = 0; j < K; j++) begin : g_lane
      logic [DATA_W-1:0] w_tap;
      logic [DATA_W-1:0] r_sk [j+1];
      // tap j is the sample (K-1-j) rows back, taken before this edge's shift
      if (j == K-1) begin : g_new
        assign w_tap = bus.serial_pixel_in;
      end else begin : g_old
        assign w_tap = w_clr ? '0 : r_line[(K-1-j)*IMG_W-1];
      end
      // j skew stages plus the output register; stage m holds the tap from m advances ago
      always_ff @(posedge clk or posedge rst)
        if (rst) for (int m = 0; m <= j; m++) r_sk[m] <= '0;
        else if (w_adv) begin
          r_sk[0] <= w_tap;
          for (int m = 1; m <= j; m++) r_sk[m] <= w_clr ? '0 : r_sk[m-1];
        end
      assign bus.rows_skewed[j*DATA_W +: DATA_W] = r_sk[j];
    end
  endgenerate
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_cnt   <= '0;
      r_col   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_adv && w_cnt_nxt == FC;
      if (w_adv) begin
        r_cnt <= w_cnt_nxt;
        // column starts at 0 on the first full window and only counts once already full
        r_col <= (w_cnt_nxt != FC || r_cnt != FC) ? '0 : (r_col == OW'(IMG_W-1) ? '0 : r_col + 1'b1);
      end
    end
  assign bus.out_valid = r_valid;
  assign bus.out_col   = r_col;
endmodule
